// File: rtl/video_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : video_pkg                                                    |
// | Shared pixel format, framebuffer-writer states and raster defaults.    |
// | Rev     : 1.0                                                          |
// +------------------------------------------------------------------------+
package video_pkg;

    localparam int          HDISP_DEF = 640;
    localparam int          VDISP_DEF = 480;
    localparam logic [31:0] FB_BASE0  = 32'h0000_0000;
    localparam logic [31:0] FB_BASE1  = 32'h0009_6000;

    // Blue occupies the top bits so the scan-out unpacking lines up field for field.
    typedef struct packed {
        logic [4:0] b;
        logic [5:0] g;
        logic [4:0] r;
    } rgb565_t;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCEPT   = 2'd1,
        BUS      = 2'd2
    } fbw_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_raster_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : fb_raster_cnt                                                 |
// | Row-major x/y pixel position with running byte address (+2/pixel).    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module fb_raster_cnt
    import video_pkg::*;
#(
    parameter int HDISP = HDISP_DEF,
    parameter int VDISP = VDISP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] base,
    output logic [31:0] addr,
    output logic        last
);
    localparam int             XW     = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int             YW     = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0]  X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(VDISP - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   addr_q, addr_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (load) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = base;
        end else if (advance) begin
            addr_d = addr_q + 32'd2;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : fb_writer                                                     |
// | Wishbone master writing an RGB565 stream into the SDRAM framebuffer.   |
// | Option : FB_WRITER_DBLBUF_EN alternates frames between BASE0/BASE1.    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module fb_writer
    import video_pkg::*;
#(
    parameter int          HDISP = HDISP_DEF,
    parameter int          VDISP = VDISP_DEF,
    parameter logic [31:0] BASE0 = FB_BASE0,
    parameter logic [31:0] BASE1 = FB_BASE1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [15:0] pix_data,
    output logic [31:0] wb_adr,
    output logic [15:0] wb_dat_ms,
    output logic [1:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic        wb_ack,
    output logic        frame_done,
    output logic        frame_err,
    output logic        fb_sel
);
    fbw_state_t  state_q, state_d;
    rgb565_t     dat_q, dat_d;
    logic        cyc_q, cyc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cnt_load, cnt_adv, cnt_last;
    logic        cur_buf;
    logic [31:0] base, cnt_addr;

    assign base = cur_buf ? BASE1 : BASE0;

    fb_raster_cnt #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_cnt (
        .clk     (CLK),
        .rst     (RST),
        .load    (cnt_load),
        .advance (cnt_adv),
        .base    (base),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        dat_d    = dat_q;
        cyc_d    = cyc_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (pix_valid && pix_sof && enable) begin
                    dat_d    = rgb565_t'(pix_data);
                    cnt_load = 1'b1;
                    cyc_d    = 1'b1;
                    state_d  = BUS;
                end
            end
            ACCEPT: begin
                if (pix_valid) begin
                    dat_d   = rgb565_t'(pix_data);
                    cyc_d   = 1'b1;
                    state_d = BUS;
                    // A misplaced SOF restarts the frame in the current buffer.
                    if (pix_sof) begin
                        cnt_load = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        cnt_adv  = 1'b1;
                    end
                end
            end
            BUS: begin
                if (wb_ack) begin
                    cyc_d = 1'b0;
                    if (cnt_last) begin
                        done_d  = 1'b1;
                        state_d = WAIT_SOF;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= WAIT_SOF;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef FB_WRITER_DBLBUF_EN
    logic buf_q, buf_d;
    logic fb_sel_q, fb_sel_d;

    always_comb begin
        buf_d    = buf_q;
        fb_sel_d = fb_sel_q;
        if (done_d) begin
            fb_sel_d = buf_q;
            buf_d    = ~buf_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_q    <= 1'b0;
            fb_sel_q <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            fb_sel_q <= fb_sel_d;
        end
    end

    assign cur_buf = buf_q;
    assign fb_sel  = fb_sel_q;
`else
    assign cur_buf = 1'b0;
    assign fb_sel  = 1'b0;
`endif

    assign pix_ready  = (state_q != BUS);
    assign wb_adr     = cnt_addr;
    assign wb_dat_ms  = dat_q;
    assign wb_sel     = 2'b11;
    assign wb_cyc     = cyc_q;
    assign wb_stb     = cyc_q;
    assign wb_we      = cyc_q;
    assign wb_cti     = 3'b000;
    assign wb_bte     = 2'b00;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_fb_writer                                                  |
// | Self-checking bench for fb_writer (HDISP=4, VDISP=2, small bases).     |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_fb_writer;
    localparam int          HD = 4;
    localparam int          VD = 2;
    localparam logic [31:0] B0 = 32'h0000_0100;
    localparam logic [31:0] B1 = 32'h0000_0200;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic        pix_ready;
    logic [31:0] wb_adr;
    logic [15:0] wb_dat_ms;
    logic [1:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack;
    logic        frame_done, frame_err, fb_sel;

    fb_writer #(.HDISP(HD), .VDISP(VD), .BASE0(B0), .BASE1(B1)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
        .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_cti(wb_cti),
        .wb_bte(wb_bte), .wb_ack(wb_ack), .frame_done(frame_done),
        .frame_err(frame_err), .fb_sel(fb_sel)
    );

    always #5 CLK = ~CLK;

    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave: programmable ack latency plus stray acks ----------------
    int   ack_lat   = 0;
    int   wait_cnt  = 0;
    logic noise_en  = 1'b0;
    logic noise_ack = 1'b0;

    always @(posedge CLK) begin
        if (!wb_stb || wb_ack) wait_cnt <= 0;
        else                   wait_cnt <= wait_cnt + 1;
    end

    always @(posedge CLK) begin
        #2;
        noise_ack = noise_en && !wb_stb && ($urandom_range(0, 2) == 0);
    end

    assign wb_ack = (wb_stb && (wait_cnt >= ack_lat)) || noise_ack;

    // ---------------- monitor ----------------
    longint      cyc = 0;
    longint      last_ack_cyc = -10;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic [31:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic        pend = 1'b0;
    logic [31:0] p_adr = '0;
    logic [15:0] p_dat = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (wb_stb) begin
            chk("ready_low_in_bus", pix_ready, 0);
            chk("cyc_we_with_stb", {wb_cyc, wb_we}, 2'b11);
            if (pend) begin
                chk("adr_stable", wb_adr, p_adr);
                chk("dat_stable", wb_dat_ms, p_dat);
            end
        end
        if (wb_cyc && wb_stb && wb_ack) begin
            wa_q.push_back(wb_adr);
            wd_q.push_back(wb_dat_ms);
            last_ack_cyc = cyc;
        end
        pend  = wb_stb && !wb_ack;
        p_adr = wb_adr;
        p_dat = wb_dat_ms;
        if (frame_done) begin
            done_cnt++;
            chk("done_one_cycle_after_ack", cyc, last_ack_cyc + 1);
        end
        if (frame_err) err_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic sof, input logic en, input logic [15:0] d);
        int g = 0;
        @(negedge CLK);
        pix_valid = 1'b1; pix_sof = sof; enable = en; pix_data = d;
        while (!pix_ready && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (!pix_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: pix_ready got 0 expected 1");
        end
        @(posedge CLK);
        #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic wait_write(output logic ok);
        int g = 0;
        while (wa_q.size() == 0 && g < 50) begin
            @(negedge CLK);
            g++;
        end
        #1;
        ok = (wa_q.size() != 0);
    endtask

    // ---------------- reference model: linear pixel index per frame ----------------
    logic        m_in = 1'b0;
    int          m_pos = 0;
    logic        m_buf = 1'b0;
    logic        m_fbsel = 1'b0;
    int          m_done = 0;
    int          m_err = 0;
    logic [31:0] ea_q[$];
    logic [15:0] ed_q[$];

    task automatic model_beat(input logic sof, input logic en, input logic [15:0] d);
        logic wr = 1'b0;
        if (!m_in) begin
            if (sof && en) begin
                m_in = 1'b1; m_pos = 0; wr = 1'b1;
            end
        end else begin
            if (sof) begin m_err++; m_pos = 0; end
            else     m_pos++;
            wr = 1'b1;
        end
        if (wr) begin
            ea_q.push_back((m_buf ? B1 : B0) + 32'(2 * m_pos));
            ed_q.push_back(d);
            if (m_pos == HD * VD - 1) begin
                m_done++;
                m_in = 1'b0;
`ifdef FB_WRITER_DBLBUF_EN
                m_fbsel = m_buf;
                m_buf   = ~m_buf;
`endif
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        sof;
        logic        en;
        logic [15:0] d;
        logic        wr;
        logic [31:0] off;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl[24];

    task automatic setv(input int i, input logic sof, input logic en, input logic wr,
                        input int off, input logic done, input logic err);
        tbl[i] = '{sof: sof, en: en, d: 16'hA000 + 16'(i), wr: wr,
                   off: 32'(off), done: done, err: err};
    endtask

    initial begin
        logic        ok;
        logic        tb_buf;
        logic        exp_fbsel;
        int          exp_done, exp_err, d0, e0, n;
        logic [31:0] tb_base;
        logic        s, e;
        logic [15:0] d;

        // 3 stray beats, a full frame, SOF with enable low, then a frame resynced at beat 5
        for (int i = 0; i < 3; i++)   setv(i, 0, 1, 0, 0, 0, 0);
        setv(3, 1, 1, 1, 0, 0, 0);
        for (int i = 4; i < 11; i++)  setv(i, 0, 1, 1, 2 * (i - 3), i == 10, 0);
        setv(11, 1, 0, 0, 0, 0, 0);
        setv(12, 1, 1, 1, 0, 0, 0);
        for (int i = 13; i < 16; i++) setv(i, 0, 1, 1, 2 * (i - 12), 0, 0);
        setv(16, 1, 1, 1, 0, 0, 1);
        for (int i = 17; i < 24; i++) setv(i, 0, !(i == 18 || i == 19), 1, 2 * (i - 16), i == 23, 0);

        // reset values
        #2;
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat", wb_dat_ms, 0);
        chk("rst_sel", wb_sel, 2'b11);
        chk("rst_cti_bte", {wb_cti, wb_bte}, 0);
        chk("rst_pulses_fbsel", {frame_done, frame_err, fb_sel}, 0);
        chk("rst_ready", pix_ready, 1);
        @(negedge CLK);
        RST = 1'b0;

        tb_buf = 1'b0; exp_fbsel = 1'b0; exp_done = 0; exp_err = 0;
        for (int i = 0; i < 24; i++) begin
            tb_base = tb_buf ? B1 : B0;
            send(tbl[i].sof, tbl[i].en, tbl[i].d);
            if (tbl[i].wr) begin
                wait_write(ok);
                if (!ok) begin
                    n_cmp++; n_bad++;
                    $display("FAIL write_timeout: vec %0d got no write expected adr %0h", i, tb_base + tbl[i].off);
                end else begin
                    chk($sformatf("vec%0d_adr", i), wa_q.pop_front(), tb_base + tbl[i].off);
                    chk($sformatf("vec%0d_dat", i), wd_q.pop_front(), tbl[i].d);
                end
            end else begin
                repeat (3) @(negedge CLK);
                #1;
                chk($sformatf("vec%0d_dropped", i), wa_q.size(), 0);
            end
            repeat (3) @(negedge CLK);
            #1;
            if (tbl[i].done) begin
                exp_done++;
                exp_fbsel = tb_buf;
`ifdef FB_WRITER_DBLBUF_EN
                tb_buf = ~tb_buf;
`endif
            end
            if (tbl[i].err) exp_err++;
            chk($sformatf("vec%0d_done_cnt", i), done_cnt, exp_done);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, exp_err);
            chk($sformatf("vec%0d_fb_sel", i), fb_sel, exp_fbsel);
        end

        // reset in the middle of a stalled write
        ack_lat = 3;
        send(1'b1, 1'b1, 16'hBEEF);
        chk("stb_before_rst", wb_stb, 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_abort_cyc_stb", {wb_cyc, wb_stb}, 0);
        chk("rst_abort_ready", pix_ready, 1);
        @(negedge CLK);
        RST = 1'b0;
        ack_lat = 0;
        wa_q.delete(); wd_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 16'h1234);
        repeat (3) @(negedge CLK);
        #1;
        chk("post_rst_no_sof_dropped", wa_q.size(), 0);
        chk("post_rst_no_done", done_cnt, d0);
        chk("post_rst_fb_sel", fb_sel, 0);

        // slow-ack frame then randomized traffic against the model
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        wa_q.delete(); wd_q.delete(); ea_q.delete(); ed_q.delete();
        m_in = 1'b0; m_pos = 0; m_buf = 1'b0; m_fbsel = 1'b0; m_done = 0; m_err = 0;
        d0 = done_cnt; e0 = err_cnt;
        ack_lat = 3;
        for (int i = 0; i < 8; i++) begin
            d = 16'h5000 + 16'(i);
            model_beat(i == 0, 1'b1, d);
            send(i == 0, 1'b1, d);
        end
        noise_en = 1'b1;
        for (int i = 0; i < 160; i++) begin
            s = ($urandom_range(0, 6) == 0);
            e = ($urandom_range(0, 4) != 0);
            d = 16'($urandom);
            ack_lat = $urandom_range(0, 3);
            model_beat(s, e, d);
            send(s, e, d);
        end
        n = 0;
        while (wb_cyc && n < 50) begin
            @(negedge CLK);
            n++;
        end
        noise_en = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rand_write_count", wa_q.size(), ea_q.size());
        while (wa_q.size() != 0 && ea_q.size() != 0) begin
            chk("rand_adr", wa_q.pop_front(), ea_q.pop_front());
            chk("rand_dat", wd_q.pop_front(), ed_q.pop_front());
        end
        chk("rand_done_cnt", done_cnt - d0, m_done);
        chk("rand_err_cnt", err_cnt - e0, m_err);
        chk("rand_fb_sel", fb_sel, m_fbsel);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
